// File: rtl/mipi_line_rd_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mipi_line_pkg
// Shared types and width helpers for the MIPI TX line read controller.
//   state_e    : controller FSM states
//   tx_word_t  : one stream word bundled with its sof/sol/eol markers
//   cnt_w()    : bits needed to hold 0..max_val (never less than 1)
//   idx_w()    : bits needed to index 0..n-1 (never less than 1)
// -----------------------------------------------------------------------------
package mipi_line_pkg;

  localparam int DATA_W     = 32;
  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_LEVEL = 3'd1,
    ST_BURST      = 3'd2,
    ST_DRAIN      = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  // Markers ride alongside the data word so they stay aligned through the skid.
  typedef struct packed {
    logic              sof;
    logic              sol;
    logic              eol;
    logic [DATA_W-1:0] data;
  } tx_word_t;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mipi_line_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// mipi_line_rd_ctrl_if
// Bundles the FIFO read port and the TX stream of the line read controller.
//   FIFO side : fifo_ren (ctrl->fifo), fifo_rdata, fifo_rempty, fifo_prog_empty
//   TX side   : tx_data, tx_valid, tx_sof, tx_sol, tx_eol (ctrl->sink), tx_ready
// modport master : the controller
// modport slave  : the environment (FIFO + packetizer)
// -----------------------------------------------------------------------------
interface mipi_line_rd_ctrl_if;
  import mipi_line_pkg::*;

  logic              fifo_ren;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_rempty;
  logic              fifo_prog_empty;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_sof;
  logic              tx_sol;
  logic              tx_eol;

  modport master (
    output fifo_ren,
    input  fifo_rdata,
    input  fifo_rempty,
    input  fifo_prog_empty,
    output tx_data,
    output tx_valid,
    input  tx_ready,
    output tx_sof,
    output tx_sol,
    output tx_eol
  );

  modport slave (
    input  fifo_ren,
    output fifo_rdata,
    output fifo_rempty,
    output fifo_prog_empty,
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    input  tx_sof,
    input  tx_sol,
    input  tx_eol
  );

endinterface

// File: rtl/mipi_line_rd_ctrl_fifo_rd_skid2.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid2
// Two-entry skid buffer between a 1-cycle-latency FIFO read stream and a
// ready/valid sink. When empty, an arriving word is presented to the sink in
// the same cycle (bypass); otherwise words leave in arrival order from storage.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_in_valid    : a FIFO word (with markers) is present on i_in_word
//   i_in_word     : incoming word + markers
//   o_out_valid   : output word valid
//   o_out_word    : output word + markers (zero when not valid)
//   i_out_ready   : sink accepts the output word
//   o_occ         : number of stored words (0..2), excludes the bypass word
// The producer must guarantee o_occ + words-in-flight never exceeds 2.
// -----------------------------------------------------------------------------
module fifo_rd_skid2
  import mipi_line_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  input  tx_word_t         i_in_word,
  output logic             o_out_valid,
  output tx_word_t         o_out_word,
  input  logic             i_out_ready,
  output logic [OCC_W-1:0] o_occ
);

  tx_word_t         r_mem [SKID_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  logic     w_has_data;
  logic     w_push;
  logic     w_pop;
  tx_word_t w_sel;

  assign w_has_data  = (r_occ != '0);
  assign o_out_valid = w_has_data | i_in_valid;

  // An arriving word is stored unless it bypasses straight to an idle,
  // ready sink.
  assign w_push = i_in_valid & ~(~w_has_data & i_out_ready);
  assign w_pop  = w_has_data & i_out_ready;

  assign w_sel      = w_has_data ? r_mem[r_rd_ptr] : i_in_word;
  assign o_out_word = o_out_valid ? w_sel : '0;
  assign o_occ      = r_occ;

  // Storage needs no reset: r_occ alone says which entries are live.
  for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
    always_ff @(posedge i_clk) begin
      if (w_push && (r_wr_ptr == 1'(gi))) begin
        r_mem[gi] <= i_in_word;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

endmodule

// File: rtl/mipi_line_rd_ctrl.sv
// -----------------------------------------------------------------------------
// mipi_line_rd_ctrl
// Read-side line scheduler for the pixel FIFO feeding the MIPI TX packetizer.
// Waits for a full line in the FIFO, bursts exactly LINE_WORDS words out to a
// ready/valid stream tagged with sof/sol/eol, repeats for LINES lines and
// inserts LINE_GAP idle cycles between lines.
// Parameters:
//   LINE_WORDS : words per line (also the FIFO prog-empty threshold)
//   LINES      : lines per frame
//   LINE_GAP   : idle cycles between a line's last word and the next level check
// Ports:
//   rclk, reset : clock, synchronous active-high reset
//   frame_start : pulse, starts a frame when idle
//   frame_done  : pulse the cycle after the frame's last word transfers
//   underflow   : sticky, FIFO went empty mid-line; cleared by frame start
//   busy        : controller not idle
//   bus         : FIFO read port and TX stream (master modport)
// -----------------------------------------------------------------------------
module mipi_line_rd_ctrl
  import mipi_line_pkg::*;
#(
  parameter int LINE_WORDS = 810,
  parameter int LINES      = 1920,
  parameter int LINE_GAP   = 16
) (
  input  logic rclk,
  input  logic reset,
  input  logic frame_start,
  output logic frame_done,
  output logic underflow,
  output logic busy,
  mipi_line_rd_ctrl_if.master bus
);

  localparam int CNT_W  = cnt_w(LINE_WORDS);
  localparam int LINE_W = idx_w(LINES);
  localparam int GAP_W  = cnt_w(LINE_GAP);

  localparam logic [CNT_W-1:0]  LW_C      = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LW_LAST   = CNT_W'(LINE_WORDS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

  state_e r_state;
  state_e w_state_next;

  logic [CNT_W-1:0]  r_rd_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic [LINE_W-1:0] r_line_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;

  // Markers for the word currently in flight from the FIFO.
  logic r_inflight;
  logic r_in_sof;
  logic r_in_sol;
  logic r_in_eol;

  logic r_underflow;
  logic r_frame_done;

  logic             w_fifo_ren;
  logic             w_busy;
  logic [OCC_W-1:0] w_skid_occ;
  tx_word_t         w_skid_in;
  tx_word_t         w_skid_out;
  logic             w_tx_valid;
  logic             w_xfer;
  logic             w_frame_accept;
  logic             w_start_burst;
  logic             w_burst_done;
  logic             w_last_xfer;
  logic             w_last_line;

  assign w_frame_accept = (r_state == ST_IDLE) & frame_start;
  assign w_start_burst  = (r_state == ST_WAIT_LEVEL) & ~bus.fifo_prog_empty;
  assign w_xfer         = w_tx_valid & bus.tx_ready;
  assign w_last_line    = (r_line_cnt == LINE_LAST);
  // Leave BURST on the read that completes the line so the last word can
  // already transfer in DRAIN; this keeps back-to-back throughput at one word
  // per cycle with no extra turnaround.
  assign w_burst_done   = w_fifo_ren & (r_rd_cnt == LW_LAST);
  assign w_last_xfer    = (r_state == ST_DRAIN) & w_xfer & (r_out_cnt == LW_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (frame_start) w_state_next = ST_WAIT_LEVEL;
      end
      ST_WAIT_LEVEL: begin
        if (!bus.fifo_prog_empty) w_state_next = ST_BURST;
      end
      ST_BURST: begin
        if (w_burst_done) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_last_xfer) begin
          if (w_last_line)        w_state_next = ST_IDLE;
          else if (LINE_GAP == 0) w_state_next = ST_WAIT_LEVEL;
          else                    w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) w_state_next = ST_WAIT_LEVEL;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // Reads only in BURST, never past the line, and only while the skid buffer
  // plus the word in flight leaves room for the word this read will return.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fifo_ren = 1'b0;
    w_busy     = (r_state != ST_IDLE);
    if (r_state == ST_BURST) begin
      w_fifo_ren = ~bus.fifo_rempty & (r_rd_cnt < LW_C) &
                   ((3'(w_skid_occ) + 3'(r_inflight)) < 3'd2);
    end
  end

  // ---------------------------------------------------------------------------
  // Counters, in-flight markers and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge rclk) begin
    if (reset) begin
      r_rd_cnt     <= '0;
      r_out_cnt    <= '0;
      r_line_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_in_sof     <= 1'b0;
      r_in_sol     <= 1'b0;
      r_in_eol     <= 1'b0;
      r_underflow  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (w_start_burst)   r_rd_cnt <= '0;
      else if (w_fifo_ren) r_rd_cnt <= r_rd_cnt + CNT_W'(1);

      if (w_start_burst) r_out_cnt <= '0;
      else if (w_xfer)   r_out_cnt <= r_out_cnt + CNT_W'(1);

      if (w_frame_accept)                  r_line_cnt <= '0;
      else if (w_last_xfer && !w_last_line) r_line_cnt <= r_line_cnt + LINE_W'(1);

      if (w_last_xfer)                                  r_gap_cnt <= GAP_LOAD;
      else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) r_gap_cnt <= r_gap_cnt - GAP_W'(1);

      // Markers are decided at read time; words leave in read order, so the
      // read index equals the output index of the same word.
      r_inflight <= w_fifo_ren;
      r_in_sol   <= w_fifo_ren & (r_rd_cnt == '0);
      r_in_eol   <= w_fifo_ren & (r_rd_cnt == LW_LAST);
      r_in_sof   <= w_fifo_ren & (r_rd_cnt == '0) & (r_line_cnt == '0);

      // A mid-line empty FIFO stalls the read but is flagged until next frame.
      if (w_frame_accept) begin
        r_underflow <= 1'b0;
      end else if ((r_state == ST_BURST) && bus.fifo_rempty && (r_rd_cnt < LW_C)) begin
        r_underflow <= 1'b1;
      end

      r_frame_done <= w_last_xfer & w_last_line;
    end
  end

  // ---------------------------------------------------------------------------
  // Skid buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    w_skid_in      = '0;
    w_skid_in.sof  = r_in_sof;
    w_skid_in.sol  = r_in_sol;
    w_skid_in.eol  = r_in_eol;
    w_skid_in.data = bus.fifo_rdata;
  end

  fifo_rd_skid2 u_skid (
    .i_clk       (rclk),
    .i_rst       (reset),
    .i_in_valid  (r_inflight),
    .i_in_word   (w_skid_in),
    .o_out_valid (w_tx_valid),
    .o_out_word  (w_skid_out),
    .i_out_ready (bus.tx_ready),
    .o_occ       (w_skid_occ)
  );

  assign bus.fifo_ren = w_fifo_ren;
  assign bus.tx_valid = w_tx_valid;
  assign bus.tx_data  = w_skid_out.data;
  assign bus.tx_sof   = w_skid_out.sof;
  assign bus.tx_sol   = w_skid_out.sol;
  assign bus.tx_eol   = w_skid_out.eol;

  assign frame_done = r_frame_done;
  assign underflow  = r_underflow;
  assign busy       = w_busy;

endmodule

// File: doc/mipi_line_rd_ctrl.md
# mipi_line_rd_ctrl

Read-side line scheduler for the 32-bit × 1k pixel FIFO that feeds the MIPI TX packetizer. It runs in the FIFO read clock domain. It waits until the FIFO holds a full line, then bursts exactly one line of words out through a ready/valid stream marked with start-of-frame/line and end-of-line. It repeats this for every line of a frame and inserts a programmable inter-line gap. Downstream backpressure is absorbed by a 2-entry skid buffer, which covers the FIFO's 1-cycle read latency.

## Interface
- `LINE_WORDS`, default 810: 32-bit words per line (1080 px × RGB24); also the FIFO programmable-empty threshold.
- `LINES`, default 1920: lines per frame.
- `LINE_GAP`, default 16: idle cycles between end of one line and the next level check; 0 is legal.
- `rclk`  in  1: clock. One clock only.
- `reset`  in  1: synchronous, active-high.
- `frame_start`  in  1: single-cycle pulse that begins a frame; ignored unless in IDLE.
- `fifo_rdata`  in  32: FIFO read data, valid the cycle after `fifo_ren`.
- `fifo_rempty`  in  1: FIFO empty.
- `fifo_prog_empty`  in  1: FIFO level below `LINE_WORDS`.
- `fifo_ren`  out  1: FIFO read enable.
- `tx_data`  out  32: stream data.
- `tx_valid`  out  1: stream valid.
- `tx_ready`  in  1: stream ready; a transfer occurs when `tx_valid & tx_ready`.
- `tx_sof`  out  1: qualifies the first word of a frame.
- `tx_sol`  out  1: qualifies the first word of each line.
- `tx_eol`  out  1: qualifies the last word of each line.
- `frame_done`  out  1: 1-cycle pulse after the last word of the frame transfers.
- `underflow`  out  1: sticky; set when a BURST read stalls on `fifo_rempty`; cleared by an accepted `frame_start`.
- `busy`  out  1: high in every state except IDLE.

## Operation
- States: IDLE, WAIT_LEVEL, BURST, DRAIN, GAP.
- IDLE:
  - On `frame_start`: clear `line_cnt` and `underflow`, then go to WAIT_LEVEL.
- WAIT_LEVEL:
  - When `fifo_prog_empty == 0`: clear `rd_cnt`, then go to BURST.
- BURST:
  - `fifo_ren = ~fifo_rempty & (rd_cnt < LINE_WORDS) & (skid_occ + inflight < 2)`.
  - `rd_cnt` increments on each `fifo_ren`.
  - When `rd_cnt` reaches `LINE_WORDS`, go to DRAIN.
  - If `fifo_rempty` is high while `rd_cnt < LINE_WORDS`, set `underflow`. Keep waiting; do not read.
- DRAIN:
  - Wait for `out_cnt` to reach `LINE_WORDS`, counting `tx_valid & tx_ready` transfers.
  - On the transfer of the last word: if `line_cnt == LINES-1`, pulse `frame_done` and go to IDLE.
  - Otherwise increment `line_cnt` and go to GAP. If `LINE_GAP == 0`, go directly to WAIT_LEVEL.
- GAP:
  - Count down `LINE_GAP` cycles, then go to WAIT_LEVEL.
- Stream markers:
  - `tx_sol`: word with `out_cnt == 0`.
  - `tx_eol`: word with `out_cnt == LINE_WORDS-1`.
  - `tx_sof`: `tx_sol & (line_cnt == 0)`.
  - Markers travel with the data word in the skid buffer, so they stay aligned under backpressure.
- Width rules:
  - `rd_cnt` and `out_cnt` are `$clog2(LINE_WORDS+1)` bits.
  - `line_cnt` is `$clog2(LINES)` bits.
  - No counter wraps. Each is cleared by the state transitions above.
- Ordering: `fifo_ren` is never high in any state but BURST, so the FIFO is never over-read past a line boundary.
- `frame_start` while `busy`: dropped, with no state change.
- Reset mid-operation: all state and counters clear and the skid buffer empties. Words already read from the FIFO are discarded. Flushing the FIFO itself is the responsibility of the upstream reset.

## Timing
- Reset values: `fifo_ren`, `tx_valid`, `tx_sof`, `tx_sol`, `tx_eol`, `frame_done`, `underflow` and `busy` are all 0; `tx_data` is 0; state is IDLE.
- `frame_start` is sampled at cycle 0.
  - WAIT_LEVEL at cycle 1.
  - If `fifo_prog_empty` is low at cycle 1: BURST and first `fifo_ren` at cycle 2.
  - First `tx_valid` at cycle 3.
- Throughput: with `tx_ready` held high and the FIFO non-empty, 1 word per cycle. A line occupies `LINE_WORDS` consecutive valid cycles.
- Backpressure: `tx_valid`, `tx_data` and the markers hold stable while `tx_ready` is low.
- `fifo_ren` deasserts within 1 cycle of the skid buffer reaching 2 committed entries. No word is lost or duplicated.
- `frame_done` is asserted the cycle after the last-word transfer.
- Line-to-line dead time with a full FIFO is `LINE_GAP + 2` cycles, measured from the last-word transfer to the next `tx_valid`.

## Structure
- Shared package `mipi_line_pkg` contains:
  - the state enum;
  - the marker bundle typedef `{sof, sol, eol, data[31:0]}`;
  - the width helper constants.
- Sub-module `fifo_rd_skid2`: 2-entry skid buffer taking a 1-cycle-latency read stream in and producing ready/valid out. It reports occupancy so the controller can compute `fifo_ren`.
- Counters and the FSM live in the top module.

## Test plan
- Basic frame with `LINE_WORDS=8`, `LINES=3`, `LINE_GAP=2`, FIFO preloaded, `tx_ready=1`:
  - 24 words out in order;
  - `tx_sof` on word 0 only;
  - `tx_sol` on words 0, 8 and 16;
  - `tx_eol` on words 7, 15 and 23;
  - each line gap 4 cycles;
  - `frame_done` pulses once.
- Level wait: hold `fifo_prog_empty=1` for 50 cycles after `frame_start` → `fifo_ren` stays 0 and `busy` is 1. First read occurs 1 cycle after `fifo_prog_empty` falls.
- Backpressure: toggle `tx_ready` with a random 50% pattern → output sequence is identical to the no-stall case and markers stay aligned. `fifo_ren` never causes a skid overflow (assertion on occupancy ≤ 2).
- Underflow: force `fifo_rempty=1` for 5 cycles mid-BURST → `underflow` sets and stays set, no extra reads occur, and the line completes once data resumes. The next `frame_start` clears `underflow`.
- `frame_start` during BURST → ignored; line and frame counts unchanged.
- Reset asserted during DRAIN with 2 words buffered → all outputs return to 0 on the next cycle and the FSM is in IDLE. A new frame then runs cleanly.
